// File: rtl/minibyte_uart_mmio.sv
// minibyte_uart_mmio
//   Memory-mapped UART transmitter for the minibyte CPU bus. CPU writes to
//   BASE_ADDR are queued in a small FIFO and drained by an 8N1 serializer.
//   A write to BASE_ADDR+1 clears the sticky overflow flag. The status
//   register at BASE_ADDR+1 is read back through a combinational read mux.
//
//   Optional feature macro: MINIBYTE_UART_PARITY_EN. When it is defined, an
//   even-parity bit is sent between the data bits and the stop bit (8E1).
//
// Parameters
//   BASE_ADDR     TX data register address; status register is at BASE_ADDR+1
//   CLKS_PER_BIT  clocks per serial bit (2..255)
//   FIFO_DEPTH    TX FIFO entries (power of 2, 2..16)
//
// Ports
//   clk_in       system clock, rising edge
//   rst_in       asynchronous active-high reset
//   addr_in      CPU address bus
//   data_in      CPU write data
//   we_in        CPU write enable
//   drive_in     CPU data-bus drive enable
//   rd_data_out  status byte when the status address is read, else 8'h00
//   rd_sel_out   high on a read (we_in=0) of either UART address
//   tx_out       serial line, idle high
//   irq_out      high while the FIFO is empty and the serializer is idle
module minibyte_uart_mmio #(
   parameter logic [7:0] BASE_ADDR    = 8'hFE,
   parameter int         CLKS_PER_BIT = 16,
   parameter int         FIFO_DEPTH   = 4
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [7:0] addr_in,
   input  logic [7:0] data_in,
   input  logic       we_in,
   input  logic       drive_in,
   output logic [7:0] rd_data_out,
   output logic       rd_sel_out,
   output logic       tx_out,
   output logic       irq_out
);

   localparam int              PW        = $clog2(FIFO_DEPTH);
   localparam int              CW        = PW + 1;
   localparam logic [7:0]      STAT_ADDR = BASE_ADDR + 8'd1;
   localparam logic [7:0]      BAUD_LAST = 8'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]   FULL_CNT  = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef MINIBYTE_UART_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t          state, state_nx;
   logic            we_d;
   logic            ovf;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count, count_nx;
   logic [7:0]      baud;
   logic [2:0]      bit_cnt;
   logic [7:0]      shreg;
`ifdef MINIBYTE_UART_PARITY_EN
   logic            par_bit;
`endif

   logic            strobe, push, pop, shift, baud_clr, baud_end, tx_nx;
   logic            fifo_empty, fifo_full, busy;
   logic [7:0]      status;

   // Rising edge of we_in qualified by drive_in: one event per CPU write
   // no matter how long the CPU holds we_in.
   assign strobe     = we_in & drive_in & ~we_d;
   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == FULL_CNT);
   // Fullness uses the pre-edge count, so a same-edge pop cannot make room.
   assign push       = strobe && (addr_in == BASE_ADDR) && !fifo_full;
   assign count_nx   = count + CW'(push) - CW'(pop);
   assign baud_end   = (baud == BAUD_LAST);
   assign busy       = (state != S_IDLE);

   assign status      = {4'b0, ovf, busy, fifo_empty, fifo_full};
   assign rd_sel_out  = !we_in && (addr_in == BASE_ADDR || addr_in == STAT_ADDR);
   assign rd_data_out = (!we_in && addr_in == STAT_ADDR) ? status : 8'h00;

   // ---------------- bus side: strobe history, overflow, FIFO ----------------
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         we_d   <= 1'b0;
         ovf    <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         we_d  <= we_in;
         count <= count_nx;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (strobe && addr_in == BASE_ADDR && fifo_full)
            ovf <= 1'b1;
         else if (strobe && addr_in == STAT_ADDR)
            ovf <= 1'b0;
      end
   end

   // Storage carries no reset; only entries between the pointers are live.
   always_ff @(posedge clk_in) begin
      if (push)
         mem[wr_ptr] <= data_in;
   end

   // ---------------- serializer FSM ----------------
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   // tx_out is registered; tx_nx is the level for the cycle after this edge.
   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      shift    = 1'b0;
      baud_clr = 1'b0;
      tx_nx    = tx_out;
      case (state)
         S_IDLE: begin
            tx_nx = 1'b1;
            if (!fifo_empty) begin
               pop      = 1'b1;
               tx_nx    = 1'b0;
               baud_clr = 1'b1;
               state_nx = S_START;
            end
         end
         S_START: begin
            if (baud_end) begin
               baud_clr = 1'b1;
               tx_nx    = shreg[0];
               state_nx = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_end) begin
               baud_clr = 1'b1;
               if (bit_cnt == 3'd7) begin
`ifdef MINIBYTE_UART_PARITY_EN
                  tx_nx    = par_bit;
                  state_nx = S_PARITY;
`else
                  tx_nx    = 1'b1;
                  state_nx = S_STOP;
`endif
               end else begin
                  shift = 1'b1;
                  tx_nx = shreg[1];
               end
            end
         end
`ifdef MINIBYTE_UART_PARITY_EN
         S_PARITY: begin
            if (baud_end) begin
               baud_clr = 1'b1;
               tx_nx    = 1'b1;
               state_nx = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (baud_end) begin
               baud_clr = 1'b1;
               // Chain straight into the next start bit when data is waiting.
               if (!fifo_empty) begin
                  pop      = 1'b1;
                  tx_nx    = 1'b0;
                  state_nx = S_START;
               end else begin
                  tx_nx    = 1'b1;
                  state_nx = S_IDLE;
               end
            end
         end
         default: begin
            tx_nx    = 1'b1;
            state_nx = S_IDLE;
         end
      endcase
   end

   // ---------------- datapath: baud/bit counters, shifter, outputs ----------------
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         baud    <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         tx_out  <= 1'b1;
         irq_out <= 1'b1;
`ifdef MINIBYTE_UART_PARITY_EN
         par_bit <= 1'b0;
`endif
      end else begin
         tx_out  <= tx_nx;
         irq_out <= (count_nx == '0) && (state_nx == S_IDLE);

         if (baud_clr || state == S_IDLE)
            baud <= '0;
         else
            baud <= baud + 8'd1;

         if (state != S_DATA)
            bit_cnt <= '0;
         else if (shift)
            bit_cnt <= bit_cnt + 3'd1;

         if (pop) begin
            shreg <= mem[rd_ptr];
`ifdef MINIBYTE_UART_PARITY_EN
            par_bit <= ^mem[rd_ptr];
`endif
         end else if (shift) begin
            shreg <= {1'b0, shreg[7:1]};
         end
      end
   end

endmodule

// File: tb/tb_minibyte_uart_mmio.sv
// Directed bench for minibyte_uart_mmio (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// tx_out/irq_out are recorded on every falling edge into queues; frames are
// compared against hand-expanded bit patterns (each bit repeated 4 samples).
module tb_minibyte_uart_mmio;
   localparam int CPB = 4;
`ifdef MINIBYTE_UART_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b1;
   logic [7:0] addr_in = 8'hFF;
   logic [7:0] data_in = 8'h00;
   logic       we_in = 1'b0;
   logic       drive_in = 1'b0;
   logic [7:0] rd_data_out;
   logic       rd_sel_out;
   logic       tx_out;
   logic       irq_out;

   minibyte_uart_mmio #(
      .BASE_ADDR   (8'hFE),
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (4)
   ) dut (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .addr_in    (addr_in),
      .data_in    (data_in),
      .we_in      (we_in),
      .drive_in   (drive_in),
      .rd_data_out(rd_data_out),
      .rd_sel_out (rd_sel_out),
      .tx_out     (tx_out),
      .irq_out    (irq_out)
   );

   always #5 clk_in = ~clk_in;

   int         n_chk  = 0;
   int         n_pass = 0;
   logic       rec    = 1'b0;
   logic       tx_q[$];
   logic       irq_q[$];
   logic [7:0] dec_q[$];

   always @(negedge clk_in) begin
      if (rec) begin
         tx_q.push_back(tx_out);
         irq_q.push_back(irq_out);
      end
   end

   task automatic chk(input string tag, input logic [87:0] got, input logic [87:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d, input int hold);
      @(negedge clk_in);
      addr_in  = a;
      data_in  = d;
      we_in    = 1'b1;
      drive_in = 1'b1;
      repeat (hold) @(negedge clk_in);
      we_in    = 1'b0;
      drive_in = 1'b0;
      addr_in  = 8'hFF;
   endtask

   task automatic start_rec();
      tx_q.delete();
      irq_q.delete();
      rec = 1'b1;
   endtask

   // Locate the first start bit, compare nb samples against exp, check that
   // irq stays low through the frame, rises right after, and nothing follows.
   task automatic check_frame(input string tag, input int nb, input logic [87:0] exp);
      int         s;
      int         hi;
      int         zeros;
      logic [87:0] cap;
      s = -1; hi = 0; zeros = 0; cap = '0;
      foreach (tx_q[i])
         if (s < 0 && tx_q[i] == 1'b0) s = i;
      if (s < 0 || s + nb >= tx_q.size()) begin
         chk({tag, " frame captured"}, 88'd0, 88'd1);
         return;
      end
      for (int i = 0; i < nb; i++) begin
         cap = {cap[86:0], tx_q[s+i]};
         if (irq_q[s+i]) hi++;
      end
      for (int i = s + nb; i < tx_q.size(); i++)
         if (tx_q[i] == 1'b0) zeros++;
      chk({tag, " bits"}, cap, exp);
      chk({tag, " irq low in frame"}, 88'(hi), 88'd0);
      chk({tag, " irq after frame"}, 88'(irq_q[s+nb]), 88'd1);
      chk({tag, " no extra frame"}, 88'(zeros), 88'd0);
   endtask

   // Mid-bit sampling decoder for the recorded line.
   task automatic decode();
      int         i;
      logic [7:0] b;
      dec_q.delete();
      i = 1;
      while (i + CPB*FB <= tx_q.size()) begin
         if (tx_q[i-1] && !tx_q[i]) begin
            for (int k = 0; k < 8; k++)
               b[k] = tx_q[i + CPB*(k+1) + CPB/2];
            dec_q.push_back(b);
            i += CPB*(FB-1);
         end else begin
            i++;
         end
      end
   endtask

   logic [7:0] exp_bytes [5] = '{8'h3C, 8'h10, 8'h11, 8'h12, 8'h13};
   int         zc;

   initial begin
      // ---------------- reset ----------------
      #12;
      chk("reset tx", 88'(tx_out), 88'd1);
      chk("reset irq", 88'(irq_out), 88'd1);
      chk("reset status", 88'(rd_data_out), 88'h02);
      @(negedge clk_in);
      rst_in = 1'b0;

      // ---------------- read select ----------------
      addr_in = 8'hFE; #1;
      chk("sel data addr", 88'(rd_sel_out), 88'd1);
      chk("rd data addr", 88'(rd_data_out), 88'h00);
      addr_in = 8'hFD; #1;
      chk("sel FD", 88'(rd_sel_out), 88'd0);
      chk("rd FD", 88'(rd_data_out), 88'h00);
      addr_in = 8'hFF; we_in = 1'b1; #1;
      chk("sel during write", 88'(rd_sel_out), 88'd0);
      we_in = 1'b0; #1;
      chk("sel status", 88'(rd_sel_out), 88'd1);
      chk("rd status", 88'(rd_data_out), 88'h02);

      // ---------------- single write, we held 3 cycles ----------------
      start_rec();
      cpu_wr(8'hFE, 8'hA5, 3);
      repeat (50) @(negedge clk_in);
      rec = 1'b0;
`ifdef MINIBYTE_UART_PARITY_EN
      check_frame("single A5", FB*CPB, 88'h0F0F00F0F0F);
`else
      check_frame("single A5", FB*CPB, 88'h0F0F00F0FF);
`endif
      chk("single status end", 88'(rd_data_out), 88'h02);

      // ---------------- back-to-back ----------------
      start_rec();
      cpu_wr(8'hFE, 8'h01, 1);
      cpu_wr(8'hFE, 8'h02, 1);
      repeat (95) @(negedge clk_in);
      rec = 1'b0;
`ifdef MINIBYTE_UART_PARITY_EN
      check_frame("b2b", 2*FB*CPB, 88'h0F0000000FF00F000000FF);
`else
      check_frame("b2b", 2*FB*CPB, 88'h0F0000000F00F000000F);
`endif

      // ---------------- overflow ----------------
      start_rec();
      cpu_wr(8'hFE, 8'h3C, 1);
      repeat (3) @(negedge clk_in);
      for (int i = 0; i < 6; i++)
         cpu_wr(8'hFE, 8'h10 + 8'(i), 1);
      #1;
      chk("ovf status", 88'(rd_data_out), 88'h0D);
      chk("ovf irq", 88'(irq_out), 88'd0);
      cpu_wr(8'hFF, 8'hAA, 1);
      #1;
      chk("ovf cleared", 88'(rd_data_out), 88'h05);
      repeat (230) @(negedge clk_in);
      rec = 1'b0;
      chk("ovf drained", 88'(rd_data_out), 88'h02);
      decode();
      chk("ovf frame count", 88'(dec_q.size()), 88'd5);
      if (dec_q.size() == 5)
         for (int i = 0; i < 5; i++)
            chk($sformatf("ovf byte %0d", i), 88'(dec_q[i]), 88'(exp_bytes[i]));

      // ---------------- 8'h07 (odd parity data -> parity bit 1) ----------------
      start_rec();
      cpu_wr(8'hFE, 8'h07, 1);
      repeat (55) @(negedge clk_in);
      rec = 1'b0;
`ifdef MINIBYTE_UART_PARITY_EN
      check_frame("byte 07", FB*CPB, 88'h0FFF00000FF);
`else
      check_frame("byte 07", FB*CPB, 88'h0FFF00000F);
`endif

      // ---------------- reset mid-frame ----------------
      cpu_wr(8'hFE, 8'h00, 1);
      cpu_wr(8'hFE, 8'h00, 1);
      repeat (6) @(negedge clk_in);
      chk("pre-reset tx low", 88'(tx_out), 88'd0);
      @(posedge clk_in);
      #2 rst_in = 1'b1;
      #1;
      chk("async reset tx", 88'(tx_out), 88'd1);
      chk("async reset irq", 88'(irq_out), 88'd1);
      chk("async reset status", 88'(rd_data_out), 88'h02);
      @(negedge clk_in);
      rst_in = 1'b0;
      start_rec();
      repeat (60) @(negedge clk_in);
      rec = 1'b0;
      zc = 0;
      foreach (tx_q[i])
         if (tx_q[i] == 1'b0) zc++;
      chk("queue discarded", 88'(zc), 88'd0);
      chk("post-reset status", 88'(rd_data_out), 88'h02);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
